cdc_handshake_tx: RTL and testbench
===================================

# cdc_handshake_tx

Source-side end of the team's four-phase req/ack clock-domain-crossing link. It accepts one data word per transfer from its local clock domain, holds it stable on `o_data`, and raises `o_req`. It waits for the remote receiver's `i_ack` through an internal synchronizer, then completes the return-to-zero phase before accepting the next word. It pairs with a receiver that synchronizes `o_req` into the destination clock and samples `o_data` once the synchronized request is seen.

## Interface
- `DATA_WIDTH`, 8: width of the transferred word.
- `SYNC_STAGES`, 2: number of flops in the `i_ack` synchronizer chain; minimum 2.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in one wait state before `o_timeout` sets; 0 disables the timeout.
- `i_clk`  in  1  local clock; the only clock in the block.
- `i_rst`  in  1  global reset, asynchronous, active-high.
- `i_valid`  in  1  a word is offered on `i_data`.
- `i_data`  in  DATA_WIDTH  word to transfer.
- `o_ready`  out  1  block can accept a word this cycle.
- `o_req`  out  1  request to remote domain, registered.
- `o_data`  out  DATA_WIDTH  held word, registered; stable whenever `o_req`=1.
- `i_ack`  in  1  acknowledge from remote domain; asynchronous to `i_clk`.
- `o_done`  out  1  one-cycle pulse when a transfer fully completes.
- `o_timeout`  out  1  sticky error flag; cleared only by reset.

## Operation
- FSM states: `IDLE`, `WAIT_ACK_HI`, `WAIT_ACK_LO`.
- `ack_s` is `i_ack` after `SYNC_STAGES` flops; all sync flops reset to 0. The FSM uses only `ack_s`.
- `IDLE`:
  - `o_ready`=1 only when `ack_s`=0 and at least one edge has passed since reset release.
  - On `i_valid`&`o_ready`: register `i_data` into `o_data`, set `o_req`=1, set `o_ready`=0, go to `WAIT_ACK_HI`.
  - `i_valid` while `o_ready`=0 is ignored. There is no buffering; the word is not captured.
- `WAIT_ACK_HI`: `o_req` and `o_data` are held. When `ack_s`=1: clear `o_req`, go to `WAIT_ACK_LO`.
- `WAIT_ACK_LO`: when `ack_s`=0: pulse `o_done` for one cycle, set `o_ready`=1, go to `IDLE`.
- Stale ack: if `ack_s`=1 while in `IDLE` (protocol violation), `o_ready` is held at 0 until `ack_s` returns to 0. No transfer starts.
- Timeout counter:
  - Clears on every state change and is held at 0 in `IDLE`.
  - Increments each cycle in either wait state and saturates.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), `o_timeout` is set. The FSM keeps waiting; it never aborts a handshake.
- Counter width is clog2(`TIMEOUT_CYCLES`+1), minimum 1 bit.

## Timing
- Reset values:
  - `o_req`=0, `o_data`=0, `o_ready`=0, `o_done`=0, `o_timeout`=0.
  - FSM in `IDLE`, sync chain all 0, timeout counter 0.
- `o_ready` rises at the first `i_clk` edge after `i_rst` deasserts (given `ack_s`=0).
- Accept at edge E: `o_req`=1 and the new `o_data` are both visible after edge E, on the same edge.
- An `i_ack` change first sampled at edge N is acted on at edge N+`SYNC_STAGES`.
- Minimum transfer period with an instant receiver is 2·(`SYNC_STAGES`+1) cycles plus the receiver's own latency.
- `o_done` and `o_ready`=1 are asserted on the same edge. A new accept is possible at the very next edge.
- Reset mid-transfer: all outputs drop to their reset values immediately (asynchronously). Any in-flight word is discarded.
- All outputs are driven directly from flops, with no combinational path from any input. `o_ready` is a register, not decoded from state.

## Test plan
- Reset release:
  - Assert `i_rst` for 3 cycles with `i_ack`=0, then deassert.
  - Required: all outputs 0 during reset; `o_ready`=1 after the first edge following release.
- Single transfer with a model receiver (`i_ack` = `o_req` delayed 3 registered cycles, `SYNC_STAGES`=2):
  - Offer `i_data`=0xA5 and accept at edge 0.
  - Required: `o_req`=1 and `o_data`=0xA5 after edge 0; `o_req`=0 after edge 6; `o_done` pulses and `o_ready`=1 after edge 12.
  - `o_data` must remain 0xA5 throughout.
- Back-to-back transfers:
  - Hold `i_valid`=1 while stepping `i_data` through 0x01..0x10.
  - Required: receiver captures all 16 words in order; no duplicates; `i_data` changes while `o_ready`=0 are ignored.
- Stale ack:
  - Hold `i_ack`=1 through reset release and for 10 cycles, with `i_valid`=1.
  - Required: `o_ready`=0 and `o_req`=0 until 3 edges after `i_ack` falls; then the first transfer proceeds normally.
- Timeout (`TIMEOUT_CYCLES`=16):
  - Accept a word with `i_ack` tied to 0.
  - Required: `o_timeout`=1 after 16 cycles in `WAIT_ACK_HI`, `o_req` still 1; flag stays set after `i_ack` is later released and the transfer completes; cleared only by `i_rst`.
- Reset mid-operation:
  - Assert `i_rst` while in `WAIT_ACK_LO`.
  - Required: `o_req`, `o_data`, `o_ready` go to 0 asynchronously; after release a fresh 0x3C transfer completes with the correct cycle counts.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a four-phase req/ack CDC link with ack synchronizer and sticky timeout
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ack,
  output logic                  o_done,
  output logic                  o_timeout
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_ACK_LO} state_t;
  state_t                  state, state_n;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    ack_s;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    ready_n, req_n, done_n, timeout_n;
  logic [DATA_WIDTH-1:0]   data_n;
  assign ack_s = sync[SYNC_STAGES-1];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      o_ready   <= 1'b0;
      o_req     <= 1'b0;
      o_data    <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], i_ack};
      state     <= state_n;
      cnt       <= cnt_n;
      o_ready   <= ready_n;
      o_req     <= req_n;
      o_data    <= data_n;
      o_done    <= done_n;
      o_timeout <= timeout_n;
    end
  end
  // Raw i_ack only vetoes readiness; in a legal handshake it is static while idle
  always_comb begin
    state_n = state;
    ready_n = o_ready;
    req_n   = o_req;
    data_n  = o_data;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (o_ready && i_valid) begin
        state_n = WAIT_ACK_HI;
        data_n  = i_data;
        req_n   = 1'b1;
        ready_n = 1'b0;
      end else begin
        ready_n = ~|{sync, i_ack};
      end
    end else if (state == WAIT_ACK_HI) begin
      if (ack_s) begin
        state_n = WAIT_ACK_LO;
        req_n   = 1'b0;
      end
    end else if (!ack_s) begin
      state_n = IDLE;
      done_n  = 1'b1;
      ready_n = 1'b1;
    end
    cnt_n     = (state_n != state || state == IDLE) ? '0 : (&cnt ? cnt : cnt + CW'(1));
    timeout_n = o_timeout | (TIMEOUT_CYCLES != 0 && state != IDLE && cnt_n == T_LIM);
  end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: table, directed and randomized checks of the handshake transmitter
module tb_cdc_handshake_tx;
  logic       i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ack;
  logic [7:0] i_data = 8'h00, o_data;
  logic       o_ready, o_req, o_done, o_timeout;
  logic       rx_en = 1'b0, ack_force = 1'b0, d1, d2, d3;
  int         total = 0, bad = 0;
  logic [7:0] rx_q[$], exp_q[$];
  int         ecnt, free_from, acc_e, wn;
  logic [7:0] last_d;
  bit         have_d;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       req;
    logic [7:0] od;
    logic       rdy;
    logic       dn;
  } vec_t;
  vec_t tbl[14];

  cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_req(o_req), .o_data(o_data), .i_ack(i_ack),
    .o_done(o_done), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Model receiver: ack follows req after three registered cycles, captures the word on req rise
  assign i_ack = rx_en ? d3 : ack_force;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) {d3, d2, d1} <= 3'b000;
    else begin
      {d3, d2, d1} <= {d2, d1, o_req};
      if (o_req && !d1) rx_q.push_back(o_data);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // One offered word, followed by the full handshake with spec timing (ack via 3-cycle receiver)
  task automatic xfer_check(input logic [7:0] d, input string n);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    check({n, "_acc"}, {o_req, o_data, o_ready}, {1'b1, d, 1'b0});
    i_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("%s_e%0d", n, k), {o_req, o_data, o_ready, o_done},
            {k < 6, d, k == 12, k == 12});
    end
  endtask

  // Reference: accept whenever offered at or after free_from; next slot 13 edges later
  task automatic step(input int mode);
    bit         v, acc;
    logic [7:0] d;
    v   = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    acc = v && (ecnt >= free_from);
    d   = (mode == 1 && acc) ? 8'(wn + 1) : 8'($urandom);
    i_valid = v;
    i_data  = d;
    if (acc) begin
      exp_q.push_back(d);
      free_from = ecnt + 13;
      acc_e     = ecnt;
      last_d    = d;
      have_d    = 1'b1;
      if (mode == 1) wn++;
    end
    tick();
    check("b2b_ready", 32'(o_ready), 32'(ecnt + 1 >= free_from));
    check("b2b_done", 32'(o_done), 32'(ecnt == acc_e + 12));
    check("b2b_req", 32'(o_req), 32'(ecnt >= acc_e && ecnt < acc_e + 6));
    if (have_d) check("b2b_data", 32'(o_data), 32'(last_d));
    ecnt++;
  endtask

  initial begin
    for (int k = 0; k < 14; k++)
      tbl[k] = '{v: k != 13, d: (k == 0) ? 8'hA5 : 8'hFF, req: k < 6, od: 8'hA5,
                 rdy: k >= 12, dn: k == 12};

    // Reset release
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_outs", {o_req, o_data, o_ready, o_done, o_timeout}, '0);
    end
    i_rst = 1'b0;
    check("rel_before_edge", 32'(o_ready), 32'(1'b0));
    tick();
    check("rel_ready", 32'(o_ready), 32'(1'b1));

    // Single transfer, table driven
    rx_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      i_valid = tbl[k].v;
      i_data  = tbl[k].d;
      tick();
      check($sformatf("tbl%0d", k), {o_req, o_data, o_ready, o_done},
            {tbl[k].req, tbl[k].od, tbl[k].rdy, tbl[k].dn});
    end

    // Back-to-back 0x01..0x10 then random offers against the reference
    rx_q.delete();
    ecnt = 0; free_from = 0; acc_e = -100; wn = 0; have_d = 1'b0;
    for (int g = 0; g < 400 && wn < 16; g++) step(1);
    check("b2b_count", 32'(wn), 32'd16);
    for (int g = 0; g < 13; g++) step(0);
    for (int g = 0; g < 400; g++) step(2);
    for (int g = 0; g < 13; g++) step(0);
    check("rx_size", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("rx_word%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    check("no_timeout", 32'(o_timeout), 32'(1'b0));

    // Stale ack through reset release
    rx_en = 1'b0; ack_force = 1'b1; i_valid = 1'b1; i_data = 8'h77; i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stale_hold", {o_ready, o_req}, 2'b00);
    end
    ack_force = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("stale_fall%0d", k), {o_ready, o_req}, {k == 3, 1'b0});
    end
    rx_en = 1'b1;
    xfer_check(8'h77, "stale_xfer");

    // Timeout with ack stuck low
    rx_en = 1'b0; i_valid = 1'b0; i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    tick();
    i_valid = 1'b1; i_data = 8'h5A;
    tick();
    check("to_acc", 32'(o_req), 32'(1'b1));
    i_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("to_e%0d", k), {o_timeout, o_req}, {k == 16, 1'b1});
    end
    for (int k = 0; k < 5; k++) tick();
    check("to_sticky", {o_timeout, o_req}, 2'b11);
    rx_en = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        tick();
        seen = o_done;
      end
      check("to_done_seen", 32'(seen), 32'(1'b1));
    end
    check("to_after_done", 32'(o_timeout), 32'(1'b1));
    i_rst = 1'b1;
    #1;
    check("to_cleared", 32'(o_timeout), 32'(1'b0));

    // Reset mid-transfer (in WAIT_ACK_LO)
    tick(); tick();
    i_rst = 1'b0;
    tick();
    i_valid = 1'b1; i_data = 8'hC3;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("mid_lo", {o_req, o_data, o_ready}, {1'b0, 8'hC3, 1'b0});
    #2 i_rst = 1'b1;
    #1;
    check("mid_async", {o_req, o_data, o_ready, o_done, o_timeout}, '0);
    for (int k = 0; k < 3; k++) tick();
    i_rst = 1'b0;
    tick();
    check("mid_ready", 32'(o_ready), 32'(1'b1));
    xfer_check(8'h3C, "mid_xfer");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
